mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side controller for the processor's word-addressed data memory: accepts load/store requests from the pipeline MEM stage, drives the memory's active / rw / index / write-data lines, and returns load data.
- Handshakes with the pipeline (valid/ready in, one-cycle response pulse out).
- Holds memory controls stable for a programmable number of cycles so the combinational memory settles before data is sampled.
- Range-checks word indices against memory depth.

Parameters:
- MEM_DEPTH, 512, number of 32-bit words in data memory; legal word index 0..MEM_DEPTH-1
- READ_WAIT, 2, cycles mem_active held high for a load before mem_rdata sampled (>=1)
- WRITE_HOLD, 1, cycles mem_active/mem_rw held high for a store (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  pipeline request present
- req_ready  output  1  unit can accept request this cycle
- req_we  input  1  0 = load, 1 = store
- req_addr  input  32  byte address; word index = req_addr[31:2]
- req_wdata  input  32  store data
- resp_valid  output  1  one-cycle pulse: access completed
- resp_data  output  32  load data (0 for stores and errors)
- resp_err  output  1  valid with resp_valid: access rejected
- busy  output  1  high whenever state != IDLE
- mem_active  output  1  to memory: access enable
- mem_rw  output  1  to memory: 0 read, 1 write
- mem_index  output  32  to memory: word index
- mem_wdata  output  32  to memory: write data
- mem_rdata  input  32  from memory: read data (combinational from mem_index)

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_err=0; busy=0; mem_active=0; mem_rw=0; mem_index=0; mem_wdata=0; wait counter=0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clk edge, latch we/addr/wdata; word index = addr[31:2].
  - Index >= MEM_DEPTH (or misaligned under the optional feature) -> RESP with err=1; memory never activated.
  - Otherwise we=0 -> READ; we=1 -> WRITE. Counter loaded with READ_WAIT-1 or WRITE_HOLD-1.
- READ:
  - mem_active=1, mem_rw=0, mem_index=latched index, all held constant.
  - Counter decrements each cycle.
  - When counter==0, sample mem_rdata into resp_data at that edge -> RESP.
- WRITE:
  - mem_active=1, mem_rw=1, mem_index/mem_wdata held constant.
  - When counter==0 -> RESP; resp_data=0.
- RESP:
  - resp_valid=1 for exactly one cycle; mem_active=0, mem_rw=0.
  - Next edge -> IDLE.
  - resp_data/resp_err hold their values until the next RESP.
- Request-to-response latency, measured from the accepting edge to the cycle resp_valid is high:
  - load = READ_WAIT+1 cycles
  - store = WRITE_HOLD+1 cycles
  - error = 1 cycle
- Outside READ/WRITE, mem_active=0 and mem_rw=0. mem_rw never toggles while mem_active is high.
- req_ready=0 in READ/WRITE/RESP. req_valid is ignored there: no queuing, no latching.
- Back-to-back: a request presented during RESP is accepted in the following IDLE cycle. Minimum spacing is 1 idle cycle between accesses.
- Address arithmetic: index is a 30-bit zero-extended field in the low bits of mem_index; upper 2 bits are 0.
- Reset mid-access: all outputs return to reset values immediately; no response is issued for the aborted access. A store aborted mid-WRITE may or may not have committed; the bench does not check the memory contents for it.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN
- Defined: req_addr[1:0] != 0 is an error. Go to RESP with resp_err=1 and resp_data=0; memory not activated.
- Undefined: req_addr[1:0] is ignored; only the range check produces errors.

Test Plan:
- Store then load: store addr=0x4, wdata=0xDEADBEEF -> mem_active/mem_rw high for WRITE_HOLD cycles with mem_index=1; then load addr=0x4 -> resp_data=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after acceptance (READ_WAIT=2).
- Range error: load addr=0x800 (index 512) -> resp_valid one cycle after acceptance, resp_err=1, resp_data=0, mem_active never asserted.
- Misaligned: store addr=0x6.
  - Macro defined -> resp_err=1, memory untouched.
  - Macro undefined -> word 1 written.
- Handshake: hold req_valid high continuously with 3 loads queued by the bench -> req_ready low during READ/RESP, each request accepted only in IDLE, 3 resp_valid pulses in order, no request lost or duplicated.
- Async reset mid-READ: assert rst asynchronously with the counter at 1 -> all outputs 0 and req_ready=1 without waiting for a clk edge; no resp_valid; next load addr=0x0 completes normally with resp_data=0.
- Stability: during every READ/WRITE window, mem_index/mem_wdata/mem_rw are unchanged cycle-to-cycle even if req_addr/req_wdata change.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus data-memory bus of mem_access_unit.
// The unit takes the slave view; the pipeline/memory side takes the master view.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        mem_active;
  logic        mem_rw;
  logic [31:0] mem_index;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err, busy,
           mem_active, mem_rw, mem_index, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err, busy,
           mem_active, mem_rw, mem_index, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// One-at-a-time load/store controller for a word-addressed combinational data memory.
// Define MEM_ALIGN_CHECK_EN to reject byte addresses whose low two bits are nonzero.
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CntMax   = (READ_WAIT > WRITE_HOLD) ? READ_WAIT : WRITE_HOLD;
  localparam int unsigned CntWidth = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam logic [CntWidth-1:0] ReadLoad  = CntWidth'(READ_WAIT - 1);
  localparam logic [CntWidth-1:0] WriteLoad = CntWidth'(WRITE_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } stateE;

  stateE               state;
  logic [CntWidth-1:0] count;
  logic                reqReady;
  logic                respValid;
  logic                respErr;
  logic [31:0]         respData;
  logic                busy;
  logic                memActive;
  logic                memRw;
  logic [31:0]         memIndex;
  logic [31:0]         memWdata;

  logic [31:0] reqIndex;
  logic        reqBad;

  assign reqIndex = {2'b00, bus.req_addr[31:2]};

`ifdef MEM_ALIGN_CHECK_EN
  assign reqBad = (reqIndex >= 32'(MEM_DEPTH)) || (bus.req_addr[1:0] != 2'b00);
`else
  assign reqBad = (reqIndex >= 32'(MEM_DEPTH));
`endif

  // NOTE: every state and output register updates with non-blocking assignments so all
  // of them sample pre-edge values; a blocking write here would leak into later reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      respData  <= '0;
      busy      <= 1'b0;
      memActive <= 1'b0;
      memRw     <= 1'b0;
      memIndex  <= '0;
      memWdata  <= '0;
    end else begin
      respValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            reqReady <= 1'b0;
            busy     <= 1'b1;
            if (reqBad) begin
              // Rejected accesses answer immediately and never touch the memory lines.
              state     <= RESP;
              respValid <= 1'b1;
              respErr   <= 1'b1;
              respData  <= '0;
            end else if (bus.req_we) begin
              state     <= WRITE;
              count     <= WriteLoad;
              memActive <= 1'b1;
              memRw     <= 1'b1;
              memIndex  <= reqIndex;
              memWdata  <= bus.req_wdata;
            end else begin
              state     <= READ;
              count     <= ReadLoad;
              memActive <= 1'b1;
              memRw     <= 1'b0;
              memIndex  <= reqIndex;
            end
          end
        end

        READ: begin
          if (count == '0) begin
            state     <= RESP;
            respValid <= 1'b1;
            respErr   <= 1'b0;
            respData  <= bus.mem_rdata;
            memActive <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end

        WRITE: begin
          if (count == '0) begin
            state     <= RESP;
            respValid <= 1'b1;
            respErr   <= 1'b0;
            respData  <= '0;
            memActive <= 1'b0;
            memRw     <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end

        RESP: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          busy     <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_data  = respData;
  assign bus.resp_err   = respErr;
  assign bus.busy       = busy;
  assign bus.mem_active = memActive;
  assign bus.mem_rw     = memRw;
  assign bus.mem_index  = memIndex;
  assign bus.mem_wdata  = memWdata;

endmodule
